// File: rtl/scan_ser_tx_pkg.sv
// Link-wide defaults and FSM encoding for the framed serial link, shared with the full_scan receive side.
// No logic; latency and backpressure are defined by the modules that import it.
package scan_ser_tx_pkg;

    localparam int DEF_DATA_W   = 16;
    localparam int DEF_HALF_PER = 1;
    localparam int DEF_GAP_BITS = 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } ser_state_t;

    // Bits needed to count 0..n-1, never less than one.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/scan_ser_tx_if.sv
// Parallel word handshake into the serial transmitter: accept = i_tx_vld & o_tx_rdy at posedge.
// Pure wiring, zero latency; the producer holds i_tx_vld until it sees o_tx_rdy.
interface scan_ser_tx_if import scan_ser_tx_pkg::*; #(
    parameter int DATA_W = DEF_DATA_W
) ();

    logic [DATA_W-1:0] i_tx_data;
    logic              i_tx_vld;
    logic              o_tx_rdy;

    modport master (output i_tx_data, output i_tx_vld, input  o_tx_rdy);
    modport slave  (input  i_tx_data, input  i_tx_vld, output o_tx_rdy);

endinterface

// File: rtl/ser_bit_tmr.sv
// Half-bit timer: o_half_tick pulses in the last cycle of every HALF_PER-cycle half period, o_phase_hi marks the clock-high half.
// i_clr restarts at the start of a high half; with i_en low the count simply holds.
module ser_bit_tmr #(
    parameter int HALF_PER = 1
) (
    input  logic sys_clk,
    input  logic rst_n,
    input  logic i_en,
    input  logic i_clr,
    output logic o_half_tick,
    output logic o_phase_hi
);

    localparam int              HW       = $clog2(HALF_PER + 1);
    localparam logic [HW-1:0]   CNT_LAST = HW'(HALF_PER - 1);

    logic [HW-1:0] r_cnt;
    logic          r_phase_hi;
    logic          w_tick;

    assign w_tick      = i_en & ~i_clr & (r_cnt == CNT_LAST);
    assign o_half_tick = w_tick;
    assign o_phase_hi  = r_phase_hi;

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt      <= '0;
            r_phase_hi <= 1'b0;
        end else if (i_clr) begin
            r_cnt      <= '0;
            r_phase_hi <= 1'b1;
        end else if (i_en) begin
            if (w_tick) begin
                r_cnt      <= '0;
                r_phase_hi <= ~r_phase_hi;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/scan_ser_tx.sv
// Framed serial transmitter: one word per 1 + 2*HALF_PER*(DATA_W+GAP_BITS) cycles, MSB first, fs on bit 0, bit 0 starts on the accept edge.
// o_tx_rdy is high only in IDLE, so a word offered while busy waits for the next IDLE cycle.
module scan_ser_tx import scan_ser_tx_pkg::*; #(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int HALF_PER = DEF_HALF_PER,
    parameter int GAP_BITS = DEF_GAP_BITS
) (
    input  logic         sys_clk,
    input  logic         rst_n,
    scan_ser_tx_if.slave tx,
    output logic         o_ser_clk,
    output logic         o_ser_fs,
    output logic         o_ser_d,
    output logic         o_busy
);

    localparam int            BW       = $clog2(DATA_W);
    localparam int            GW       = cnt_w(GAP_BITS);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);

    ser_state_t        r_state, w_state;
    logic [DATA_W-1:0] r_sr, w_sr;
    logic [BW-1:0]     r_bit, w_bit;
    logic [GW-1:0]     r_gap, w_gap;
    logic              r_ser_clk, w_ser_clk;
    logic              r_ser_fs, w_ser_fs;
    logic              r_ser_d, w_ser_d;
    logic              r_tx_rdy, w_tx_rdy;
    logic              r_busy, w_busy;

    logic w_tmr_en, w_tmr_clr, w_half_tick, w_phase_hi;

    assign w_tmr_en = (r_state != ST_IDLE);

    ser_bit_tmr #(
        .HALF_PER (HALF_PER)
    ) u_bit_tmr (
        .sys_clk     (sys_clk),
        .rst_n       (rst_n),
        .i_en        (w_tmr_en),
        .i_clr       (w_tmr_clr),
        .o_half_tick (w_half_tick),
        .o_phase_hi  (w_phase_hi)
    );

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_sr      <= '0;
            r_bit     <= '0;
            r_gap     <= '0;
            r_ser_clk <= 1'b0;
            r_ser_fs  <= 1'b0;
            r_ser_d   <= 1'b0;
            r_tx_rdy  <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_sr      <= w_sr;
            r_bit     <= w_bit;
            r_gap     <= w_gap;
            r_ser_clk <= w_ser_clk;
            r_ser_fs  <= w_ser_fs;
            r_ser_d   <= w_ser_d;
            r_tx_rdy  <= w_tx_rdy;
            r_busy    <= w_busy;
        end
    end

    always_comb begin
        w_state   = r_state;
        w_sr      = r_sr;
        w_bit     = r_bit;
        w_gap     = r_gap;
        w_ser_clk = r_ser_clk;
        w_ser_fs  = r_ser_fs;
        w_ser_d   = r_ser_d;
        w_tx_rdy  = r_tx_rdy;
        w_busy    = r_busy;
        w_tmr_clr = 1'b0;

        unique case (r_state)
            ST_IDLE: begin
                w_tx_rdy  = 1'b1;
                w_ser_clk = 1'b0;
                w_ser_fs  = 1'b0;
                w_ser_d   = 1'b0;
                w_busy    = 1'b0;
                // Bit 0 goes out on the accept edge itself.
                if (tx.i_tx_vld && r_tx_rdy) begin
                    w_state   = ST_SHIFT;
                    w_sr      = tx.i_tx_data;
                    w_bit     = '0;
                    w_ser_clk = 1'b1;
                    w_ser_fs  = 1'b1;
                    w_ser_d   = tx.i_tx_data[DATA_W-1];
                    w_tx_rdy  = 1'b0;
                    w_busy    = 1'b1;
                    w_tmr_clr = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (w_half_tick) begin
                    if (w_phase_hi) begin
                        w_ser_clk = 1'b0;
                    end else if (r_bit == BIT_LAST) begin
                        w_ser_clk = 1'b0;
                        w_ser_fs  = 1'b0;
                        w_ser_d   = 1'b0;
                        if (GAP_BITS == 0) begin
                            w_state  = ST_IDLE;
                            w_tx_rdy = 1'b1;
                            w_busy   = 1'b0;
                        end else begin
                            w_state = ST_GAP;
                            w_gap   = '0;
                        end
                    end else begin
                        // Rotate so r_sr[DATA_W-2] is always the bit about to go out.
                        w_bit     = r_bit + 1'b1;
                        w_sr      = {r_sr[DATA_W-2:0], r_sr[DATA_W-1]};
                        w_ser_d   = r_sr[DATA_W-2];
                        w_ser_clk = 1'b1;
                        w_ser_fs  = 1'b0;
                    end
                end
            end
            ST_GAP: begin
                if (w_half_tick && !w_phase_hi) begin
                    if (r_gap == GAP_LAST) begin
                        w_state  = ST_IDLE;
                        w_tx_rdy = 1'b1;
                        w_busy   = 1'b0;
                    end else begin
                        w_gap = r_gap + 1'b1;
                    end
                end
            end
            default: begin
                w_state   = ST_IDLE;
                w_ser_clk = 1'b0;
                w_ser_fs  = 1'b0;
                w_ser_d   = 1'b0;
                w_tx_rdy  = 1'b0;
                w_busy    = 1'b0;
            end
        endcase
    end

    assign tx.o_tx_rdy = r_tx_rdy;
    assign o_ser_clk   = r_ser_clk;
    assign o_ser_fs    = r_ser_fs;
    assign o_ser_d     = r_ser_d;
    assign o_busy      = r_busy;

endmodule

// File: tb/tb_scan_ser_tx.sv
// Directed bench for scan_ser_tx: DUT A uses defaults, DUT B uses HALF_PER=3, GAP_BITS=0.
// A falling-edge receiver on DUT A plays the part of full_scan and collects words framed by fs.
module tb_scan_ser_tx;

    logic sys_clk;
    logic rst_n;

    int n_cmp = 0;
    int n_err = 0;

    logic a_clk, a_fs, a_d, a_busy;
    logic b_clk, b_fs, b_d, b_busy;

    scan_ser_tx_if #(.DATA_W(16)) ifa ();
    scan_ser_tx_if #(.DATA_W(16)) ifb ();

    scan_ser_tx #(.DATA_W(16), .HALF_PER(1), .GAP_BITS(1)) u_dut_a (
        .sys_clk   (sys_clk),
        .rst_n     (rst_n),
        .tx        (ifa),
        .o_ser_clk (a_clk),
        .o_ser_fs  (a_fs),
        .o_ser_d   (a_d),
        .o_busy    (a_busy)
    );

    scan_ser_tx #(.DATA_W(16), .HALF_PER(3), .GAP_BITS(0)) u_dut_b (
        .sys_clk   (sys_clk),
        .rst_n     (rst_n),
        .tx        (ifb),
        .o_ser_clk (b_clk),
        .o_ser_fs  (b_fs),
        .o_ser_d   (b_d),
        .o_busy    (b_busy)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // Receiver model: sample d on each ser_clk fall, fs at that bit restarts the word.
    logic [15:0] rx_q[$];
    logic [15:0] m_cur;
    int          m_nb, m_pulses, m_fs_cyc;
    logic        m_prev_clk, m_prev_fs, m_prev_d;

    initial begin
        m_cur = '0; m_nb = 0; m_pulses = 0; m_fs_cyc = 0;
        m_prev_clk = 1'b0; m_prev_fs = 1'b0; m_prev_d = 1'b0;
    end

    always @(negedge sys_clk) begin
        if (!rst_n) begin
            m_cur = '0; m_nb = 0;
            m_prev_clk = 1'b0; m_prev_fs = 1'b0; m_prev_d = 1'b0;
        end else begin
            if (m_prev_clk && !a_clk) begin
                if (m_prev_fs) begin
                    m_cur = '0;
                    m_nb  = 0;
                end
                m_cur = {m_cur[14:0], m_prev_d};
                m_nb  = m_nb + 1;
                if (m_nb == 16) begin
                    rx_q.push_back(m_cur);
                    m_nb = 0;
                end
            end
            if (!m_prev_clk && a_clk) m_pulses = m_pulses + 1;
            if (a_fs) m_fs_cyc = m_fs_cyc + 1;
            m_prev_clk = a_clk;
            m_prev_fs  = a_fs;
            m_prev_d   = a_d;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    // {ser_clk, fs, d, rdy, busy}
    function automatic logic [4:0] vec_a();
        return {a_clk, a_fs, a_d, ifa.o_tx_rdy, a_busy};
    endfunction

    function automatic logic [4:0] vec_b();
        return {b_clk, b_fs, b_d, ifb.o_tx_rdy, b_busy};
    endfunction

    task automatic wait_rdy(input bit sel_b, input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            if ((sel_b ? ifb.o_tx_rdy : ifa.o_tx_rdy) === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        logic [4:0] g;
        rst_n = 1'b0;
        ifa.i_tx_vld = 1'b1; ifa.i_tx_data = 16'hA5C3;
        ifb.i_tx_vld = 1'b0; ifb.i_tx_data = 16'h0000;
        repeat (3) tick();
        g = vec_a(); n_cmp++;
        if (g !== 5'b00000) begin n_err++; $display("FAIL reset_hold_a: got %b want %b", g, 5'b00000); end
        g = vec_b(); n_cmp++;
        if (g !== 5'b00000) begin n_err++; $display("FAIL reset_hold_b: got %b want %b", g, 5'b00000); end
        rst_n = 1'b1;
        #1;
        g = vec_a(); n_cmp++;
        if (g !== 5'b00000) begin n_err++; $display("FAIL reset_release_a: got %b want %b", g, 5'b00000); end
        tick();
        g = vec_a(); n_cmp++;
        if (g !== 5'b00010) begin n_err++; $display("FAIL reset_first_edge_a: got %b want %b", g, 5'b00010); end
        g = vec_b(); n_cmp++;
        if (g !== 5'b00010) begin n_err++; $display("FAIL reset_first_edge_b: got %b want %b", g, 5'b00010); end
        tick();
        g = vec_a(); n_cmp++;
        if (g !== 5'b11101) begin n_err++; $display("FAIL reset_vld_second_edge: got %b want %b", g, 5'b11101); end
        ifa.i_tx_vld = 1'b0;
    endtask

    task automatic test_single_word();
        logic [4:0]  g, e;
        logic [15:0] w;
        bit          ok;
        w = 16'hA5C3;
        wait_rdy(1'b0, 60, ok);
        n_cmp++;
        if (!ok) begin n_err++; $display("FAIL single_wait_rdy: got timeout want rdy"); end
        rx_q.delete(); m_pulses = 0; m_fs_cyc = 0;
        ifa.i_tx_data = w; ifa.i_tx_vld = 1'b1;
        tick();
        ifa.i_tx_vld = 1'b0; ifa.i_tx_data = 16'h0000;
        for (int j = 0; j <= 34; j++) begin
            e = {(j < 32) && (j % 2 == 0), j < 2, (j < 32) ? w[15 - j/2] : 1'b0, j == 34, j < 34};
            g = vec_a(); n_cmp++;
            if (g !== e) begin n_err++; $display("FAIL single_wave[%0d]: got %b want %b", j, g, e); end
            if (j < 34) tick();
        end
        n_cmp++;
        if (m_fs_cyc !== 2) begin n_err++; $display("FAIL single_fs_cycles: got %0d want 2", m_fs_cyc); end
        n_cmp++;
        if (m_pulses !== 16) begin n_err++; $display("FAIL single_clk_pulses: got %0d want 16", m_pulses); end
        n_cmp++;
        if (rx_q.size() !== 1) begin n_err++; $display("FAIL single_rx_count: got %0d want 1", rx_q.size()); end
        else begin
            n_cmp++;
            if (rx_q[0] !== w) begin n_err++; $display("FAIL single_rx_word: got %h want %h", rx_q[0], w); end
        end
    endtask

    task automatic test_back_to_back();
        int  acc_t[8];
        int  n_acc;
        bit  acc, ok;
        n_acc = 0;
        wait_rdy(1'b0, 60, ok);
        rx_q.delete();
        ifa.i_tx_data = 16'd0; ifa.i_tx_vld = 1'b1;
        for (int cyc = 0; cyc < 200; cyc++) begin
            acc = ifa.o_tx_rdy && ifa.i_tx_vld;
            tick();
            if (acc && n_acc < 8) begin
                acc_t[n_acc] = cyc;
                n_acc++;
                ifa.i_tx_data = ifa.i_tx_data + 16'd1;
            end
            if (rx_q.size() >= 4) break;
        end
        ifa.i_tx_vld = 1'b0;
        n_cmp++;
        if (rx_q.size() < 4 || n_acc < 4) begin
            n_err++; $display("FAIL b2b_progress: got %0d rx %0d acc want 4 rx 4 acc", rx_q.size(), n_acc);
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_cmp++;
                if (acc_t[i+1] - acc_t[i] !== 35) begin
                    n_err++; $display("FAIL b2b_spacing[%0d]: got %0d want 35", i, acc_t[i+1] - acc_t[i]);
                end
            end
            for (int i = 0; i < 4; i++) begin
                n_cmp++;
                if (rx_q[i] !== 16'(i)) begin n_err++; $display("FAIL b2b_rx[%0d]: got %h want %h", i, rx_q[i], 16'(i)); end
            end
        end
        wait_rdy(1'b0, 80, ok);
        n_cmp++;
        if (!ok) begin n_err++; $display("FAIL b2b_drain: got timeout want rdy"); end
    endtask

    task automatic test_half_per3();
        logic [4:0]  g, e;
        logic [15:0] w;
        int          bi;
        bit          ok;
        w = 16'h8001;
        wait_rdy(1'b1, 150, ok);
        n_cmp++;
        if (!ok) begin n_err++; $display("FAIL hp3_wait_rdy: got timeout want rdy"); end
        ifb.i_tx_data = w; ifb.i_tx_vld = 1'b1;
        tick();
        ifb.i_tx_data = 16'hC000;
        for (int j = 0; j <= 97; j++) begin
            bi = j / 6;
            if (j < 96)
                e = {(j % 6) < 3, j < 6, (bi == 0) || (bi == 15), 1'b0, 1'b1};
            else if (j == 96)
                e = 5'b00010;
            else
                e = 5'b11101;
            g = vec_b(); n_cmp++;
            if (g !== e) begin n_err++; $display("FAIL hp3_wave[%0d]: got %b want %b", j, g, e); end
            if (j < 97) tick();
        end
        ifb.i_tx_vld = 1'b0;
        wait_rdy(1'b1, 150, ok);
        n_cmp++;
        if (!ok) begin n_err++; $display("FAIL hp3_drain: got timeout want rdy"); end
    endtask

    task automatic test_reset_mid();
        logic [4:0] g;
        bit         ok;
        wait_rdy(1'b0, 60, ok);
        ifa.i_tx_data = 16'hFFFF; ifa.i_tx_vld = 1'b1;
        tick();
        ifa.i_tx_vld = 1'b0;
        repeat (14) tick();
        g = vec_a(); n_cmp++;
        if (g !== 5'b10101) begin n_err++; $display("FAIL midrst_bit7: got %b want %b", g, 5'b10101); end
        #1 rst_n = 1'b0;
        #1;
        g = vec_a(); n_cmp++;
        if (g !== 5'b00000) begin n_err++; $display("FAIL midrst_async: got %b want %b", g, 5'b00000); end
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        g = vec_a(); n_cmp++;
        if (g !== 5'b00010) begin n_err++; $display("FAIL midrst_no_residual1: got %b want %b", g, 5'b00010); end
        tick();
        g = vec_a(); n_cmp++;
        if (g !== 5'b00010) begin n_err++; $display("FAIL midrst_no_residual2: got %b want %b", g, 5'b00010); end
        rx_q.delete(); m_fs_cyc = 0;
        ifa.i_tx_data = 16'h3C5A; ifa.i_tx_vld = 1'b1;
        tick();
        ifa.i_tx_vld = 1'b0;
        g = vec_a(); n_cmp++;
        if (g !== 5'b11001) begin n_err++; $display("FAIL midrst_restart: got %b want %b", g, 5'b11001); end
        wait_rdy(1'b0, 60, ok);
        n_cmp++;
        if (rx_q.size() !== 1) begin n_err++; $display("FAIL midrst_rx_count: got %0d want 1", rx_q.size()); end
        else begin
            n_cmp++;
            if (rx_q[0] !== 16'h3C5A) begin n_err++; $display("FAIL midrst_rx_word: got %h want %h", rx_q[0], 16'h3C5A); end
        end
        n_cmp++;
        if (m_fs_cyc !== 2) begin n_err++; $display("FAIL midrst_fs_cycles: got %0d want 2", m_fs_cyc); end
    endtask

    task automatic test_vld_toggle();
        logic [15:0] exp_q[$];
        bit          acc, ok;
        wait_rdy(1'b0, 60, ok);
        rx_q.delete();
        for (int cyc = 0; cyc < 120; cyc++) begin
            ifa.i_tx_vld  = (cyc % 5) < 3;
            ifa.i_tx_data = 16'h1357 + 16'(cyc * 241);
            acc = ifa.o_tx_rdy && ifa.i_tx_vld;
            if (acc) exp_q.push_back(ifa.i_tx_data);
            tick();
        end
        ifa.i_tx_vld = 1'b0;
        wait_rdy(1'b0, 80, ok);
        n_cmp++;
        if (!ok) begin n_err++; $display("FAIL toggle_drain: got timeout want rdy"); end
        n_cmp++;
        if (exp_q.size() < 3) begin n_err++; $display("FAIL toggle_accepts: got %0d want >=3", exp_q.size()); end
        n_cmp++;
        if (rx_q.size() !== exp_q.size()) begin
            n_err++; $display("FAIL toggle_rx_count: got %0d want %0d", rx_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                n_cmp++;
                if (rx_q[i] !== exp_q[i]) begin n_err++; $display("FAIL toggle_rx[%0d]: got %h want %h", i, rx_q[i], exp_q[i]); end
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        ifa.i_tx_vld = 1'b0; ifa.i_tx_data = '0;
        ifb.i_tx_vld = 1'b0; ifb.i_tx_data = '0;
        test_reset();
        test_single_word();
        test_back_to_back();
        test_half_per3();
        test_reset_mid();
        test_vld_toggle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
